parser_ingress_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single Ethernet/IP header-parser pipeline between `N_PORTS` AXI-stream ingress ports. It locks a grant for a whole packet (first beat through `tlast`), then inserts an idle gap so the downstream parser FSM returns to idle before the next packet. A stall watchdog aborts a packet whose source stops mid-frame and flushes that port's remainder. It sits directly in front of the header parser and drives its `s_axis_*` slave.

---
 rtl/parser_pkg.sv | 25 ++
 rtl/parser_ingress_arbiter_rr_pick.sv | 41 ++++
 rtl/parser_ingress_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_parser_ingress_arbiter.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// -----------------------------------------------------------------------------
// parser_pkg
// Shared types and helpers for the header-parser front end.
//   arb_state_t       : ingress arbiter FSM state
//   port_w()          : index width for a count, never narrower than one bit
//   ABORT_TDATA_BYTE  : byte pattern replicated across tdata on an abort beat
// -----------------------------------------------------------------------------
package parser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FWD   = 2'd1,
        S_ABORT = 2'd2,
        S_GAP   = 2'd3
    } arb_state_t;

    // Abort beats carry all-zero data; replicated to the bus width by users.
    localparam logic [7:0] ABORT_TDATA_BYTE = 8'h00;

    // max(1, $clog2(n)): a single port still needs a one-bit index.
    function automatic int port_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parser_ingress_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches the request vector
// starting one position after last_idx and wrapping modulo N.
// Ports:
//   req        in  N       request vector
//   last_idx   in  IDX_W   index of the most recent grant
//   pick       out N       one-hot winner (zero when nothing requests)
//   pick_idx   out IDX_W   binary index of the winner
//   pick_valid out 1       at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_valid
);

    // Walk from the farthest candidate to the nearest so the closest
    // requester after last_idx is the final (winning) assignment.
    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(last_idx) + k) % N);
            if (req[cand]) begin
                pick       = '0;
                pick[cand] = 1'b1;
                pick_idx   = cand;
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parser_ingress_arbiter.sv
// -----------------------------------------------------------------------------
// parser_ingress_arbiter
// Packet-granular round-robin arbiter sharing one header-parser pipeline
// between N_PORTS AXI-stream ingress ports. A grant is held from the first
// beat through tlast, followed by GAP_CYC idle cycles. A stall watchdog
// replaces a stalled packet's tail with a synthetic abort beat and flushes
// the rest of that packet at the source.
// Ports:
//   aclk, areset             clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast per-port ingress (port p at [p*DATA_W +: DATA_W])
//   s_axis_tready            per-port ready
//   m_axis_tdata/tvalid/tlast/tready  stream to the parser
//   m_axis_tid               granted port index
//   m_axis_tuser_abort       high only on the synthetic abort beat
//   grant                    one-hot current grant, zero when none
//   pkt_cnt                  completed packets forwarded (wraps)
//   abort_cnt                watchdog aborts (saturates)
// -----------------------------------------------------------------------------
module parser_ingress_arbiter
    import parser_pkg::*;
#(
    parameter int N_PORTS     = 4,
    parameter int DATA_W      = 64,
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 64,
    localparam int PORT_W     = port_w(N_PORTS)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [N_PORTS*DATA_W-1:0] s_axis_tdata,
    input  logic [N_PORTS-1:0]        s_axis_tvalid,
    input  logic [N_PORTS-1:0]        s_axis_tlast,
    output logic [N_PORTS-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [PORT_W-1:0]         m_axis_tid,
    output logic                      m_axis_tuser_abort,
    output logic [N_PORTS-1:0]        grant,
    output logic [31:0]               pkt_cnt,
    output logic [15:0]               abort_cnt
);

    localparam int WD_W = port_w(TIMEOUT_CYC + 1);
    localparam arb_state_t POST_PKT_STATE = (GAP_CYC == 0) ? S_IDLE : S_GAP;

    arb_state_t          state_reg, state_next;
    logic [N_PORTS-1:0]  grant_reg, grant_next;
    logic [N_PORTS-1:0]  flush_reg, flush_next;
    logic [PORT_W-1:0]   last_grant_reg, last_grant_next;
    logic [WD_W-1:0]     wd_cnt_reg, wd_cnt_next;
    logic [2:0]          gap_cnt_reg, gap_cnt_next;
    logic [31:0]         pkt_cnt_reg, pkt_cnt_next;
    logic [15:0]         abort_cnt_reg, abort_cnt_next;

    logic [N_PORTS-1:0]  eligible;
    logic [N_PORTS-1:0]  flush_done;
    logic [N_PORTS-1:0]  pick;
    logic [PORT_W-1:0]   pick_idx;
    logic                pick_valid;

    // Granted source, selected by last_grant (which holds the current
    // grant index while in S_FWD / S_ABORT).
    logic                g_tvalid;
    logic                g_tlast;
    logic [DATA_W-1:0]   g_tdata;

    assign g_tvalid = s_axis_tvalid[last_grant_reg];
    assign g_tlast  = s_axis_tlast[last_grant_reg];
    assign g_tdata  = s_axis_tdata[int'(last_grant_reg)*DATA_W +: DATA_W];

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
            // Flushing ports sink beats in every state; otherwise only the
            // forwarding port sees the parser's ready.
            assign s_axis_tready[gi] = flush_reg[gi]
                                     | ((state_reg == S_FWD) & grant_reg[gi] & m_axis_tready);
            assign flush_done[gi]    = flush_reg[gi] & s_axis_tvalid[gi] & s_axis_tlast[gi];
            assign eligible[gi]      = s_axis_tvalid[gi] & ~flush_reg[gi];
        end
    endgenerate

    rr_pick #(
        .N     (N_PORTS),
        .IDX_W (PORT_W)
    ) u_pick (
        .req        (eligible),
        .last_idx   (last_grant_reg),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        wd_cnt_next     = wd_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        pkt_cnt_next    = pkt_cnt_reg;
        abort_cnt_next  = abort_cnt_reg;
        flush_next      = flush_reg & ~flush_done;

        case (state_reg)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_next      = pick;
                    last_grant_next = pick_idx;
                    wd_cnt_next     = '0;
                    state_next      = S_FWD;
                end
            end
            S_FWD: begin
                if (g_tvalid) begin
                    // Any valid cycle restarts the stall count, even when the
                    // parser is backpressuring.
                    wd_cnt_next = '0;
                    if (m_axis_tready && g_tlast) begin
                        pkt_cnt_next = pkt_cnt_reg + 32'd1;
                        grant_next   = '0;
                        gap_cnt_next = '0;
                        state_next   = POST_PKT_STATE;
                    end
                end else if (TIMEOUT_CYC != 0) begin
                    // Abort on the cycle the count would reach TIMEOUT_CYC.
                    if (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1)) begin
                        wd_cnt_next = '0;
                        state_next  = S_ABORT;
                    end else begin
                        wd_cnt_next = wd_cnt_reg + 1'b1;
                    end
                end
            end
            S_ABORT: begin
                if (m_axis_tready) begin
                    if (abort_cnt_reg != 16'hFFFF) begin
                        abort_cnt_next = abort_cnt_reg + 16'd1;
                    end
                    flush_next[last_grant_reg] = 1'b1;
                    grant_next   = '0;
                    gap_cnt_next = '0;
                    state_next   = POST_PKT_STATE;
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == 3'(GAP_CYC - 1)) begin
                    gap_cnt_next = '0;
                    state_next   = S_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 3'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg      <= S_IDLE;
            grant_reg      <= '0;
            flush_reg      <= '0;
            last_grant_reg <= PORT_W'(N_PORTS - 1);
            wd_cnt_reg     <= '0;
            gap_cnt_reg    <= '0;
            pkt_cnt_reg    <= '0;
            abort_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            flush_reg      <= flush_next;
            last_grant_reg <= last_grant_next;
            wd_cnt_reg     <= wd_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            pkt_cnt_reg    <= pkt_cnt_next;
            abort_cnt_reg  <= abort_cnt_next;
        end
    end

    // Pass-through mux: no buffering between the granted source and the parser.
    always_comb begin
        m_axis_tdata       = '0;
        m_axis_tvalid      = 1'b0;
        m_axis_tlast       = 1'b0;
        m_axis_tid         = '0;
        m_axis_tuser_abort = 1'b0;
        case (state_reg)
            S_FWD: begin
                m_axis_tdata  = g_tdata;
                m_axis_tvalid = g_tvalid;
                m_axis_tlast  = g_tlast;
                m_axis_tid    = last_grant_reg;
            end
            S_ABORT: begin
                m_axis_tdata       = {(DATA_W/8){ABORT_TDATA_BYTE}};
                m_axis_tvalid      = 1'b1;
                m_axis_tlast       = 1'b1;
                m_axis_tid         = last_grant_reg;
                m_axis_tuser_abort = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant     = grant_reg;
    assign pkt_cnt   = pkt_cnt_reg;
    assign abort_cnt = abort_cnt_reg;

endmodule

// File: tb/tb_parser_ingress_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parser_ingress_arbiter
// Per-port source drivers feed queued beats; a monitor pops an expected-beat
// scoreboard on every m_axis handshake. Scenario tasks run in sequence.
// -----------------------------------------------------------------------------
module tb_parser_ingress_arbiter;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int GAP = 1;
    localparam int TO  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              areset;
    wire  [N*DW-1:0]   s_tdata;
    wire  [N-1:0]      s_tvalid;
    wire  [N-1:0]      s_tlast;
    wire  [N-1:0]      src_busy;
    logic [N-1:0]      s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_rdy;
    logic [1:0]        m_tid;
    logic              m_abort;
    logic [N-1:0]      grant;
    logic [31:0]       pkt_cnt;
    logic [15:0]       abort_cnt;

    parser_ingress_arbiter #(
        .N_PORTS     (N),
        .DATA_W      (DW),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TO)
    ) dut (
        .aclk               (clk),
        .areset             (areset),
        .s_axis_tdata       (s_tdata),
        .s_axis_tvalid      (s_tvalid),
        .s_axis_tlast       (s_tlast),
        .s_axis_tready      (s_tready),
        .m_axis_tdata       (m_tdata),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tlast       (m_tlast),
        .m_axis_tready      (m_rdy),
        .m_axis_tid         (m_tid),
        .m_axis_tuser_abort (m_abort),
        .grant              (grant),
        .pkt_cnt            (pkt_cnt),
        .abort_cnt          (abort_cnt)
    );

    typedef struct { logic [DW-1:0] data; logic last; int idle; } src_beat_t;
    typedef struct { logic [DW-1:0] data; logic last; logic [1:0] tid; logic abort; } exp_beat_t;
    typedef struct { int cyc; int idx; } gnt_ev_t;

    src_beat_t src_q[N][$];
    exp_beat_t exp_q[$];
    gnt_ev_t   gnt_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int abort_cyc = -1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Source drivers: idle cycles first, then hold the beat until accepted.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_src
            logic [DW-1:0] td;
            logic          tv;
            logic          tl;
            logic          busy;
            assign s_tdata[gi*DW +: DW] = td;
            assign s_tvalid[gi]         = tv;
            assign s_tlast[gi]          = tl;
            assign src_busy[gi]         = busy;
            initial begin
                src_beat_t b;
                logic acc;
                td = '0; tv = 1'b0; tl = 1'b0; busy = 1'b0;
                @(posedge clk); #1;
                forever begin
                    if (src_q[gi].size() == 0) begin
                        busy = 1'b0;
                        tv   = 1'b0;
                        @(posedge clk); #1;
                    end else begin
                        busy = 1'b1;
                        b = src_q[gi].pop_front();
                        tv = 1'b0;
                        repeat (b.idle) begin
                            @(posedge clk); #1;
                        end
                        td = b.data; tl = b.last; tv = 1'b1;
                        acc = 1'b0;
                        while (!acc) begin
                            @(negedge clk);
                            acc = s_tready[gi];
                            @(posedge clk); #1;
                        end
                        tv = 1'b0;
                    end
                end
            end
        end
    endgenerate

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [DW-1:0] mk_data(input int p, input int k, input int b);
        return {8'(p), 40'(k), 16'(b)};
    endfunction

    function automatic bit all_idle();
        bit r = (exp_q.size() == 0) && (src_busy == '0);
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) r = 0;
        return r;
    endfunction

    task automatic push_src(input int p, input logic [DW-1:0] d, input logic l, input int idle);
        src_beat_t b;
        b.data = d; b.last = l; b.idle = idle;
        src_q[p].push_back(b);
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic l, input int tid, input logic ab);
        exp_beat_t e;
        e.data = d; e.last = l; e.tid = 2'(tid); e.abort = ab;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (all_idle()) begin
                ok = 1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [N-1:0] prev_grant;
        exp_beat_t e;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                prev_grant = '0;
            end else begin
                if (grant != '0 && prev_grant == '0) begin
                    gnt_log.push_back('{cyc, onehot_idx(grant)});
                    $display("grant port %0d at cycle %0d", onehot_idx(grant), cyc);
                end
                prev_grant = grant;
                if (m_tvalid && m_rdy) begin
                    checks++;
                    if (m_abort) abort_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got tid=%0d data=%h last=%0d abort=%0d, required no beat",
                                 m_tid, m_tdata, m_tlast, m_abort);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_tdata !== e.data || m_tlast !== e.last || m_tid !== e.tid || m_abort !== e.abort) begin
                            errors++;
                            $display("FAIL sb_beat: got tid=%0d data=%h last=%0d abort=%0d, required tid=%0d data=%h last=%0d abort=%0d",
                                     m_tid, m_tdata, m_tlast, m_abort, e.tid, e.data, e.last, e.abort);
                        end else begin
                            $display("beat tid=%0d data=%h last=%0d abort=%0d cycle=%0d",
                                     m_tid, m_tdata, m_tlast, m_abort, cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        areset = 1'b1;
        m_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_tvalid, m_tlast, m_abort, m_tid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid/last/abort/tid=%b, required 00000", {m_tvalid, m_tlast, m_abort, m_tid});
        end
        checks++;
        if (m_tdata !== '0) begin
            errors++;
            $display("FAIL reset_tdata: got %h, required 0", m_tdata);
        end
        checks++;
        if (s_tready !== '0 || grant !== '0) begin
            errors++;
            $display("FAIL reset_ready_grant: got tready=%b grant=%b, required 0/0", s_tready, grant);
        end
        checks++;
        if (pkt_cnt !== 32'd0 || abort_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got pkt=%0d abort=%0d, required 0/0", pkt_cnt, abort_cnt);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int p0 = int'(pkt_cnt);
        gnt_log.delete();
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < N; p++) begin
                push_src(p, mk_data(p, 10 + r, 0), 1'b1, 0);
                push_exp(mk_data(p, 10 + r, 0), 1'b1, p, 1'b0);
            end
        end
        drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_timeout: got traffic still pending, required drained");
        end
        checks++;
        if (gnt_log.size() != 8) begin
            errors++;
            $display("FAIL rr_grant_count: got %0d, required 8", gnt_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (gnt_log[i].idx != i % N) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got port %0d, required %0d", i, gnt_log[i].idx, i % N);
                end
                if (i > 0) begin
                    checks++;
                    if (gnt_log[i].cyc - gnt_log[i-1].cyc != GAP + 2) begin
                        errors++;
                        $display("FAIL rr_spacing[%0d]: got %0d cycles, required %0d",
                                 i, gnt_log[i].cyc - gnt_log[i-1].cyc, GAP + 2);
                    end
                end
            end
        end
        checks++;
        if (int'(pkt_cnt) - p0 != 8) begin
            errors++;
            $display("FAIL rr_pkt_cnt: got +%0d, required +8", int'(pkt_cnt) - p0);
        end
    endtask

    task automatic test_two_ports();
        bit ok;
        int p0 = int'(pkt_cnt);
        gnt_log.delete();
        @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            push_src(0, mk_data(0, 20, b), b == 2, 0);
            push_src(2, mk_data(2, 21, b), b == 2, 0);
        end
        for (int b = 0; b < 3; b++) push_exp(mk_data(0, 20, b), b == 2, 0, 1'b0);
        for (int b = 0; b < 3; b++) push_exp(mk_data(2, 21, b), b == 2, 2, 1'b0);
        drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL two_timeout: got traffic still pending, required drained");
        end
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0].idx != 0 || gnt_log[1].idx != 2) begin
            errors++;
            $display("FAIL two_order: got %0d grants, required ports 0 then 2", gnt_log.size());
        end else begin
            checks++;
            if (gnt_log[1].cyc - gnt_log[0].cyc != 3 + GAP + 1) begin
                errors++;
                $display("FAIL two_spacing: got %0d cycles, required %0d",
                         gnt_log[1].cyc - gnt_log[0].cyc, 3 + GAP + 1);
            end
        end
        checks++;
        if (int'(pkt_cnt) - p0 != 2) begin
            errors++;
            $display("FAIL two_pkt_cnt: got +%0d, required +2", int'(pkt_cnt) - p0);
        end
    endtask

    task automatic test_backpressure();
        bit done = 0;
        int p0 = int'(pkt_cnt);
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            push_src(1, mk_data(1, 25, b), b == 3, 0);
            push_exp(mk_data(1, 25, b), b == 3, 1, 1'b0);
        end
        for (int k = 0; k < 60 && !done; k++) begin
            @(posedge clk);
            #1 m_rdy = (k % 2 == 0);
            @(negedge clk);
            if (grant[1]) begin
                checks++;
                if (s_tready[1] !== m_rdy) begin
                    errors++;
                    $display("FAIL bp_tready: got %b, required %b", s_tready[1], m_rdy);
                end
            end
            if (all_idle()) done = 1;
        end
        m_rdy = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL bp_timeout: got traffic still pending, required drained");
        end
        checks++;
        if (int'(pkt_cnt) - p0 != 1) begin
            errors++;
            $display("FAIL bp_pkt_cnt: got +%0d, required +1", int'(pkt_cnt) - p0);
        end
    endtask

    task automatic test_abort();
        bit seen = 0;
        bit done = 0;
        int disc = 0;
        int a0 = int'(abort_cnt);
        gnt_log.delete();
        abort_cyc = -1;
        @(negedge clk);
        for (int b = 0; b < 5; b++) push_src(1, mk_data(1, 30, b), b == 4, (b == 2) ? TO : 0);
        push_exp(mk_data(1, 30, 0), 1'b0, 1, 1'b0);
        push_exp(mk_data(1, 30, 1), 1'b0, 1, 1'b0);
        push_exp('0, 1'b1, 1, 1'b1);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (grant == 4'b0010) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_grant_wait: got grant=%b, required 0010", grant);
        end
        for (int b = 0; b < 2; b++) begin
            push_src(3, mk_data(3, 31, b), b == 1, 0);
            push_exp(mk_data(3, 31, b), b == 1, 3, 1'b0);
        end
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (s_tvalid[1] && s_tready[1] && !grant[1]) disc++;
            if (all_idle()) done = 1;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL abort_timeout: got traffic still pending, required drained");
        end
        checks++;
        if (disc != 3) begin
            errors++;
            $display("FAIL abort_discard: got %0d flushed beats, required 3", disc);
        end
        checks++;
        if (int'(abort_cnt) - a0 != 1) begin
            errors++;
            $display("FAIL abort_cnt: got +%0d, required +1", int'(abort_cnt) - a0);
        end
        checks++;
        if (gnt_log.size() != 2 || gnt_log[1].idx != 3) begin
            errors++;
            $display("FAIL abort_next_grant: got %0d grants, required port 1 then port 3", gnt_log.size());
        end else begin
            checks++;
            if (abort_cyc - gnt_log[0].cyc != 2 + TO) begin
                errors++;
                $display("FAIL abort_timing: got abort %0d cycles after grant, required %0d",
                         abort_cyc - gnt_log[0].cyc, 2 + TO);
            end
        end
    endtask

    task automatic test_no_abort();
        bit ok;
        int a0 = int'(abort_cnt);
        int p0 = int'(pkt_cnt);
        @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            push_src(0, mk_data(0, 40, b), b == 4, (b == 2) ? TO - 1 : 0);
            push_exp(mk_data(0, 40, b), b == 4, 0, 1'b0);
        end
        drain(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL noabort_timeout: got traffic still pending, required drained");
        end
        checks++;
        if (int'(abort_cnt) != a0 || int'(pkt_cnt) - p0 != 1) begin
            errors++;
            $display("FAIL noabort_counts: got abort +%0d pkt +%0d, required +0/+1",
                     int'(abort_cnt) - a0, int'(pkt_cnt) - p0);
        end
    endtask

    task automatic test_reset_midpacket();
        bit seen = 0;
        bit ok;
        @(negedge clk);
        for (int b = 0; b < 4; b++) push_src(1, mk_data(1, 50, b), b == 3, 0);
        push_exp(mk_data(1, 50, 0), 1'b0, 1, 1'b0);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (grant == 4'b0010) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_grant_wait: got grant=%b, required 0010", grant);
        end
        for (int b = 0; b < 2; b++) begin
            push_src(0, mk_data(0, 51, b), b == 1, 0);
            push_src(2, mk_data(2, 52, b), b == 1, 0);
        end
        @(posedge clk);
        #1 areset = 1'b1;
        @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_tvalid, m_tlast, m_abort, m_tid} !== 5'b0 || m_tdata !== '0) begin
            errors++;
            $display("FAIL rst_outputs: got valid/last/abort/tid=%b tdata=%h, required all 0",
                     {m_tvalid, m_tlast, m_abort, m_tid}, m_tdata);
        end
        checks++;
        if (s_tready !== '0 || grant !== '0) begin
            errors++;
            $display("FAIL rst_ready_grant: got tready=%b grant=%b, required 0/0", s_tready, grant);
        end
        checks++;
        if (pkt_cnt !== 32'd0 || abort_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_counters: got pkt=%0d abort=%0d, required 0/0", pkt_cnt, abort_cnt);
        end
        for (int b = 0; b < 2; b++) push_exp(mk_data(0, 51, b), b == 1, 0, 1'b0);
        for (int b = 2; b < 4; b++) push_exp(mk_data(1, 50, b), b == 3, 1, 1'b0);
        for (int b = 0; b < 2; b++) push_exp(mk_data(2, 52, b), b == 1, 2, 1'b0);
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001 || m_tid !== 2'd0) begin
            errors++;
            $display("FAIL rst_first_grant: got grant=%b tid=%0d, required 0001/0", grant, m_tid);
        end
        drain(100, ok);
        checks++;
        if (!ok || pkt_cnt !== 32'd3) begin
            errors++;
            $display("FAIL rst_drain: got drained=%0d pkt=%0d, required 1/3", ok, pkt_cnt);
        end
    endtask

    initial begin
        areset = 1'b1;
        m_rdy  = 1'b1;
        test_reset();
        test_round_robin();
        test_two_ports();
        test_backpressure();
        test_abort();
        test_no_abort();
        test_reset_midpacket();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, required summary before time limit");
        $fatal(1, "simulation time limit");
    end

endmodule
